// File: rtl/prime_number_if.sv
// Bundle of the scanner's limit input and its result outputs.
// The bench drives through master and the scanner sits on slave.
interface prime_number_if #(
  parameter int WIDTH = 11
);
  logic [WIDTH-1:0] numMax;
  logic             prime;
  logic [WIDTH-1:0] numberChecked;
  logic [WIDTH-1:0] numberOfPrimes;

  modport master (
    output numMax,
    input  prime,
    input  numberChecked,
    input  numberOfPrimes
  );

  modport slave (
    input  numMax,
    output prime,
    output numberChecked,
    output numberOfPrimes
  );
endinterface

// File: rtl/prime_number.sv
// Sequential prime scanner: emits 0, 1, 2, ... up to numMax, one value per clock,
// together with a primality flag and a running count of primes found.
module prime_number #(
  parameter int WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  prime_number_if.slave        bus
);

  // Trial divisors up to 43 cover every composite below 47*47 = 2209.
  localparam logic [13:0][5:0] DIVISORS = {
    6'd43, 6'd41, 6'd37, 6'd31, 6'd29, 6'd23, 6'd19,
    6'd17, 6'd13, 6'd11, 6'd7,  6'd5,  6'd3,  6'd2
  };

  function automatic logic is_prime(input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] d;
    logic             result;
    result = (n >= WIDTH'(2));
    for (int i = 0; i < 14; i++) begin
      d = {{(WIDTH-6){1'b0}}, DIVISORS[i]};
      if ((n != d) && ((n % d) == '0)) begin
        result = 1'b0;
      end
    end
    return result;
  endfunction

  // cand carries one extra bit so it can step past all-ones and stop the scan.
  logic [WIDTH:0]   cand         = '0;
  logic             started      = 1'b0;
  logic             prime_reg    = 1'b0;
  logic [WIDTH-1:0] checked_reg  = '0;
  logic [WIDTH-1:0] count_reg    = '0;

  logic             emit;
  logic             cand_prime;

  assign emit       = !started || (cand <= {1'b0, bus.numMax});
  assign cand_prime = is_prime(cand[WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      cand        <= '0;
      started     <= 1'b0;
      prime_reg   <= 1'b0;
      checked_reg <= '0;
      count_reg   <= '0;
    end else if (emit) begin
      cand        <= cand + 1'b1;
      started     <= 1'b1;
      prime_reg   <= cand_prime;
      checked_reg <= cand[WIDTH-1:0];
      count_reg   <= count_reg + {{(WIDTH-1){1'b0}}, cand_prime};
    end
  end

  assign bus.prime          = prime_reg;
  assign bus.numberChecked  = checked_reg;
  assign bus.numberOfPrimes = count_reg;

endmodule

// File: tb/tb_prime_number.sv
// Directed bench for prime_number: checks every emitted value against an
// independent trial-division model and hand-computed prime counts.
module tb_prime_number;

  logic clk = 1'b0;
  logic rst = 1'b0;

  prime_number_if #(.WIDTH(11)) bus ();

  prime_number #(.WIDTH(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int lastVal  = -1;
  int refCount = 0;

  function automatic int refPrime(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 0;
    end
    return 1;
  endfunction

  task automatic applyStimulus(input logic rstVal, input int limit);
    rst        = rstVal;
    bus.numMax = 11'(limit);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int expChecked,
                             input int expPrime, input int expCount);
    checks++;
    assert (int'(bus.numberChecked) === expChecked) else begin
      failures++;
      $error("FAIL %s numberChecked: observed %0d expected %0d", tag, bus.numberChecked, expChecked);
    end
    checks++;
    assert (int'(bus.prime) === expPrime) else begin
      failures++;
      $error("FAIL %s prime: observed %0d expected %0d (value %0d)", tag, bus.prime, expPrime, expChecked);
    end
    checks++;
    assert (int'(bus.numberOfPrimes) === expCount) else begin
      failures++;
      $error("FAIL %s numberOfPrimes: observed %0d expected %0d", tag, bus.numberOfPrimes, expCount);
    end
  endtask

  // One reset edge; outputs must all read zero afterwards.
  task automatic doReset(input string tag, input int limit);
    applyStimulus(1'b1, limit);
    lastVal  = -1;
    refCount = 0;
    checkOutput(tag, 0, 0, 0);
  endtask

  // Advance the reference model one edge with the given limit and compare.
  task automatic scanStep(input string tag, input int limit);
    applyStimulus(1'b0, limit);
    if (lastVal < limit) begin
      lastVal  = lastVal + 1;
      refCount = refCount + refPrime(lastVal);
    end
    checkOutput(tag, lastVal, refPrime(lastVal), refCount);
  endtask

  initial begin
    int countSeq[11] = '{0, 0, 1, 2, 2, 3, 3, 4, 4, 4, 4};
    int seqIdx;

    bus.numMax = '0;
    rst        = 1'b0;
    @(negedge clk);

    // Scan 0..100: 25 primes.
    doReset("reset", 100);
    for (int k = 0; k <= 100; k++) scanStep("scan100", 100);
    checkOutput("scan100_final", 100, 0, 25);

    // Limit 10 with extra edges: hand-written count sequence, then hold.
    doReset("reset10", 10);
    for (int k = 0; k < 15; k++) begin
      scanStep("scan10", 10);
      seqIdx = (k <= 10) ? k : 10;
      checkOutput("scan10_seq", seqIdx, refPrime(seqIdx), countSeq[seqIdx]);
    end
    checkOutput("scan10_hold", 10, 0, 4);

    // Limit 0 and limit 1: nothing prime, outputs hold.
    doReset("reset0", 0);
    for (int k = 0; k < 4; k++) scanStep("scan0", 0);
    checkOutput("scan0_hold", 0, 0, 0);
    doReset("reset1", 1);
    for (int k = 0; k < 5; k++) scanStep("scan1", 1);
    checkOutput("scan1_hold", 1, 0, 0);

    // Full range: stops at 2047 (= 23*89) with 309 primes, never wraps.
    doReset("reset2047", 2047);
    for (int k = 0; k < 2052; k++) scanStep("scan2047", 2047);
    checkOutput("scan2047_final", 2047, 0, 309);

    // Reset in the middle of a scan, then rescan to 20.
    doReset("resetMid", 100);
    for (int k = 0; k <= 50; k++) scanStep("mid", 100);
    checkOutput("mid_at50", 50, 0, 15);
    doReset("mid_reset", 20);
    for (int k = 0; k < 24; k++) scanStep("rescan20", 20);
    checkOutput("rescan20_final", 20, 0, 8);

    // Raise the limit after holding: resumes at 21 and ends at 30 with 10 primes.
    doReset("resetRaise", 20);
    for (int k = 0; k < 25; k++) scanStep("raise20", 20);
    checkOutput("raise_hold20", 20, 0, 8);
    scanStep("raise_first", 30);
    checkOutput("raise_resume", 21, 0, 8);
    for (int k = 0; k < 12; k++) scanStep("raise30", 30);
    checkOutput("raise_final", 30, 0, 10);

    // Lowering the limit below the current value halts immediately.
    scanStep("lower", 5);
    checkOutput("lower_hold", 30, 0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
